// File: rtl/cnt_regs_core.sv
// Programmable W-bit up-counter with CONTROL/STATUS/THRESHOLD registers.
// Reads are combinational and always ready; writes and counting take effect on the next clk_i edge.
module cnt_regs_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         reg_valid_i,
  input  logic         reg_write_i,
  input  logic [31:0]  reg_addr_i,
  input  logic [31:0]  reg_wdata_i,
  input  logic [3:0]   reg_wstrb_i,
  output logic [31:0]  reg_rdata_o,
  output logic         reg_error_o,
  output logic         reg_ready_o,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o,
  output logic         en_o,
  output logic         clr_o
);

  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [3:0] ADDR_THR  = 4'h8;

  if (W < 1 || W > 32) begin : g_w_check
    $error("cnt_regs_core: W=%0d outside legal range 1..32", W);
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         en_q, en_d;
  logic         clr_q, clr_d;
  logic         tc_sts_q, tc_sts_d;
  logic [31:0]  thr_q, thr_d;

  logic hit_ctrl, hit_stat, hit_thr, addr_ok;
  logic wr_ctrl, wr_stat, wr_thr;
  logic cnt_match, tc;
  logic unused_addr;

  assign unused_addr = ^reg_addr_i[31:4];

  assign hit_ctrl = (reg_addr_i[3:0] == ADDR_CTRL);
  assign hit_stat = (reg_addr_i[3:0] == ADDR_STAT);
  assign hit_thr  = (reg_addr_i[3:0] == ADDR_THR);
  assign addr_ok  = hit_ctrl | hit_stat | hit_thr;

  assign wr_ctrl = reg_valid_i & reg_write_i & hit_ctrl & reg_wstrb_i[0];
  assign wr_stat = reg_valid_i & reg_write_i & hit_stat & reg_wstrb_i[0];
  assign wr_thr  = reg_valid_i & reg_write_i & hit_thr;

  // Upper THRESHOLD bits are storage only; the compare sees just the counter width.
  assign cnt_match = (cnt_q == thr_q[W-1:0]);
  assign tc        = en_q & ~clr_q & ~ld_i & cnt_match;

  always_comb begin
    en_d     = en_q;
    clr_d    = 1'b0;
    tc_sts_d = tc_sts_q;
    thr_d    = thr_q;
    if (wr_ctrl) begin
      en_d  = reg_wdata_i[0];
      clr_d = reg_wdata_i[1];
    end
    if (wr_stat && reg_wdata_i[0]) tc_sts_d = 1'b0;
    // A terminal count in the same cycle as the W1C must not be lost.
    if (tc) tc_sts_d = 1'b1;
    if (wr_thr) begin
      for (int b = 0; b < 4; b++) begin
        if (reg_wstrb_i[b]) thr_d[8*b +: 8] = reg_wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_q)                   cnt_d = '0;
    else if (ld_i)               cnt_d = ld_val_i;
    else if (en_q && cnt_match)  cnt_d = '0;
    else if (en_q)               cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      tc_sts_q <= 1'b0;
      thr_q    <= 32'hFFFF_FFFF;
    end else begin
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      tc_sts_q <= tc_sts_d;
      thr_q    <= thr_d;
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    if (reg_valid_i && !reg_write_i) begin
      if (hit_ctrl)      reg_rdata_o = {31'b0, en_q};
      else if (hit_stat) reg_rdata_o = {31'b0, tc_sts_q};
      else if (hit_thr)  reg_rdata_o = thr_q;
    end
  end

  assign reg_error_o = reg_valid_i & ~addr_ok;
  assign reg_ready_o = 1'b1;
  assign cnt_o       = cnt_q;
  assign tc_o        = tc;
  assign en_o        = en_q;
  assign clr_o       = clr_q;

endmodule

// File: tb/tb_cnt_regs_core.sv
// Directed bench for cnt_regs_core: a 32-bit instance for the register/counter
// behaviour and a 4-bit instance for natural wrap and mid-count asynchronous reset.
module tb_cnt_regs_core;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_valid_i, reg_write_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o, reg_ready_o;
  logic        ld_i;
  logic [31:0] ld_val_i;
  logic [31:0] cnt_o;
  logic        tc_o, en_o, clr_o;

  logic        rst4_n;
  logic        r4_valid, r4_write;
  logic [31:0] r4_addr, r4_wdata;
  logic [3:0]  r4_wstrb;
  logic [31:0] r4_rdata;
  logic        r4_error, r4_ready;
  logic        ld4;
  logic [3:0]  ld_val4;
  logic [3:0]  cnt4;
  logic        tc4, en4, clr4;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  cnt_regs_core #(.W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i), .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
    .ld_i(ld_i), .ld_val_i(ld_val_i), .cnt_o(cnt_o),
    .tc_o(tc_o), .en_o(en_o), .clr_o(clr_o)
  );

  cnt_regs_core #(.W(4)) dut4 (
    .clk_i(clk_i), .rst_ni(rst4_n),
    .reg_valid_i(r4_valid), .reg_write_i(r4_write), .reg_addr_i(r4_addr),
    .reg_wdata_i(r4_wdata), .reg_wstrb_i(r4_wstrb), .reg_rdata_o(r4_rdata),
    .reg_error_o(r4_error), .reg_ready_o(r4_ready),
    .ld_i(ld4), .ld_val_i(ld_val4), .cnt_o(cnt4),
    .tc_o(tc4), .en_o(en4), .clr_o(clr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    reg_valid_i = 1'b1; reg_write_i = 1'b1;
    reg_addr_i = a; reg_wdata_i = d; reg_wstrb_i = s;
    tick();
    reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_wstrb_i = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_err);
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = a; reg_wdata_i = '0;
    #1;
    chk({tag, "_rdata"}, reg_rdata_o, exp);
    chk({tag, "_err"}, {31'b0, reg_error_o}, {31'b0, exp_err});
    reg_valid_i = 1'b0;
  endtask

  task automatic wr4(input logic [31:0] a, input logic [31:0] d);
    r4_valid = 1'b1; r4_write = 1'b1; r4_addr = a; r4_wdata = d; r4_wstrb = 4'hF;
    tick();
    r4_valid = 1'b0; r4_write = 1'b0; r4_wstrb = 4'h0;
  endtask

  initial begin
    rst_ni = 1'b0; rst4_n = 1'b0;
    reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0; reg_wdata_i = 0; reg_wstrb_i = 0;
    ld_i = 0; ld_val_i = 0;
    r4_valid = 0; r4_write = 0; r4_addr = 0; r4_wdata = 0; r4_wstrb = 0;
    ld4 = 0; ld_val4 = 0;

    // Reset state
    #1;
    chk("rst_cnt", cnt_o, 32'h0);
    chk("rst_tc", {31'b0, tc_o}, 32'h0);
    chk("rst_en", {31'b0, en_o}, 32'h0);
    chk("rst_clr", {31'b0, clr_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1; rst4_n = 1'b1;
    tick();
    rd("rst_ctrl", 32'h0, 32'h0, 1'b0);
    rd("rst_stat", 32'h4, 32'h0, 1'b0);
    rd("rst_thr", 32'h8, 32'hFFFF_FFFF, 1'b0);
    chk("ready", {31'b0, reg_ready_o}, 32'h1);

    // Threshold 3: sequence 1,2,3,0,1 with tc only at 3
    wr(32'h8, 32'h3, 4'hF);
    wr(32'h0, 32'h1, 4'h1);
    chk("en_after_wr", {31'b0, en_o}, 32'h1);
    chk("cnt_start", cnt_o, 32'h0);
    begin
      logic [31:0] seq [5];
      seq = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("seq_cnt_%0d", k), cnt_o, seq[k]);
        chk($sformatf("seq_tc_%0d", k), {31'b0, tc_o}, {31'b0, seq[k] == 32'd3});
      end
    end
    rd("stat_set", 32'h4, 32'h1, 1'b0);
    wr(32'h4, 32'h1, 4'h1);
    rd("stat_w1c", 32'h4, 32'h0, 1'b0);
    wr(32'h0, 32'h0, 4'h1);
    chk("disabled_cnt", cnt_o, 32'h3);
    chk("disabled_en", {31'b0, en_o}, 32'h0);
    chk("disabled_tc", {31'b0, tc_o}, 32'h0);
    wr(32'h8, 32'hFFFF_FFFF, 4'hF);

    // Load while enabled, then load coinciding with the clear pulse
    ld_i = 1'b1; ld_val_i = 32'd5;
    tick();
    ld_i = 1'b0;
    wr(32'h0, 32'h1, 4'h1);
    chk("ld_5", cnt_o, 32'd5);
    ld_i = 1'b1; ld_val_i = 32'h100;
    #1;
    chk("ld_tc_low", {31'b0, tc_o}, 32'h0);
    tick();
    ld_i = 1'b0;
    chk("ld_100", cnt_o, 32'h100);
    tick();
    chk("ld_101", cnt_o, 32'h101);
    wr(32'h0, 32'h3, 4'h1);
    chk("clr_pulse", {31'b0, clr_o}, 32'h1);
    chk("clr_cnt_before", cnt_o, 32'h102);
    ld_i = 1'b1; ld_val_i = 32'h55;
    tick();
    ld_i = 1'b0;
    chk("clr_beats_ld", cnt_o, 32'h0);
    chk("clr_drop", {31'b0, clr_o}, 32'h0);
    tick();
    chk("clr_resume", cnt_o, 32'h1);

    // CONTROL = 0x3 while count is 7
    ld_i = 1'b1; ld_val_i = 32'd7;
    tick();
    ld_i = 1'b0;
    chk("cnt7", cnt_o, 32'd7);
    wr(32'h0, 32'h3, 4'h1);
    chk("c3_clr", {31'b0, clr_o}, 32'h1);
    chk("c3_en", {31'b0, en_o}, 32'h1);
    chk("c3_cnt", cnt_o, 32'd8);
    tick();
    chk("c3_zero", cnt_o, 32'd0);
    chk("c3_clr_one_cycle", {31'b0, clr_o}, 32'h0);
    tick();
    chk("c3_resume", cnt_o, 32'd1);
    rd("c3_ctrl", 32'h0, 32'h1, 1'b0);

    // Byte strobes, ignored CONTROL strobe, error accesses
    wr(32'h8, 32'hAABB_CCDD, 4'b0101);
    rd("thr_strb", 32'h8, 32'hFFBB_FFDD, 1'b0);
    wr(32'h0, 32'h0, 4'b1110);
    rd("ctrl_nostrb", 32'h0, 32'h1, 1'b0);
    reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = 32'hC;
    reg_wdata_i = 32'h0; reg_wstrb_i = 4'hF;
    #1;
    chk("err_wr_C", {31'b0, reg_error_o}, 32'h1);
    tick();
    reg_addr_i = 32'h1;
    #1;
    chk("err_wr_1", {31'b0, reg_error_o}, 32'h1);
    tick();
    reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_wstrb_i = 4'h0;
    rd("err_rd_C", 32'hC, 32'h0, 1'b1);
    rd("err_thr_kept", 32'h8, 32'hFFBB_FFDD, 1'b0);
    rd("err_ctrl_kept", 32'h0, 32'h1, 1'b0);
    rd("err_stat_kept", 32'h4, 32'h0, 1'b0);

    // Terminal count at full 32-bit threshold; set beats simultaneous W1C
    ld_i = 1'b1; ld_val_i = 32'hFFBB_FFDC;
    tick();
    ld_i = 1'b0;
    chk("pre_tc", {31'b0, tc_o}, 32'h0);
    tick();
    chk("tc_at_thr", {31'b0, tc_o}, 32'h1);
    tick();
    chk("wrap_thr", cnt_o, 32'h0);
    rd("stat_after_tc", 32'h4, 32'h1, 1'b0);
    ld_i = 1'b1; ld_val_i = 32'hFFBB_FFDC;
    tick();
    ld_i = 1'b0;
    tick();
    chk("tc_again", {31'b0, tc_o}, 32'h1);
    wr(32'h4, 32'h1, 4'h1);
    rd("set_wins", 32'h4, 32'h1, 1'b0);
    wr(32'h4, 32'h1, 4'h1);
    rd("w1c_after", 32'h4, 32'h0, 1'b0);

    // W = 4: natural wrap at 15 and asynchronous reset mid-count
    wr4(32'h0, 32'h1);
    chk("w4_en", {31'b0, en4}, 32'h1);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("w4_cnt_%0d", i), {28'b0, cnt4}, 32'(i % 16));
      chk($sformatf("w4_tc_%0d", i), {31'b0, tc4}, {31'b0, i == 15});
      tick();
    end
    tick();
    chk("w4_mid", {28'b0, cnt4}, 32'd2);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("w4_rst_cnt", {28'b0, cnt4}, 32'h0);
    chk("w4_rst_en", {31'b0, en4}, 32'h0);
    chk("w4_rst_tc", {31'b0, tc4}, 32'h0);
    @(negedge clk_i);
    rst4_n = 1'b1;
    tick();
    chk("w4_hold", {28'b0, cnt4}, 32'h0);
    r4_valid = 1'b1; r4_write = 1'b0; r4_addr = 32'h8;
    #1;
    chk("w4_thr_rst", r4_rdata, 32'hFFFF_FFFF);
    r4_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_regs_core.md
Name: cnt_regs_core

Overview:
- Programmable W-bit up-counter plus its register-interface control/status registers (enable, clear, threshold, sticky terminal-count flag).
- Sits under the OBI counter wrapper:
  - the wrapper drives the load port from OBI writes and reads cnt_o;
  - the register port is mapped on the peripheral register bus;
  - tc_o goes to the host as an interrupt.

Parameters:
- W, 32, counter width in bits; legal range 1..32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- reg_valid_i  in  1  register access request
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  32  byte address; only bits [3:0] decoded
- reg_wdata_i  in  32  write data
- reg_wstrb_i  in  4  byte strobes for writes
- reg_rdata_o  out  32  read data
- reg_error_o  out  1  access error
- reg_ready_o  out  1  access complete
- ld_i  in  1  load counter with ld_val_i
- ld_val_i  in  W  load value
- cnt_o  out  W  current counter value
- tc_o  out  1  terminal-count pulse / interrupt
- en_o  out  1  current CONTROL.EN
- clr_o  out  1  clear pulse in progress; the wrapper uses it to refuse OBI grants

Behaviour:
- Reset values: counter 0, EN 0, clr_o 0, STATUS.TC 0, THRESHOLD 32'hFFFF_FFFF. Consequently cnt_o = 0, tc_o = 0, en_o = 0.
- Register map, byte offset:
  - 0x0 CONTROL: bit0 EN (RW). bit1 CLR (write-1 pulse, always reads 0). Other bits read 0, writes ignored.
  - 0x4 STATUS: bit0 TC, sticky. Set by tc_o, cleared by writing 1 (W1C). Other bits read 0.
  - 0x8 THRESHOLD: 32-bit RW; wstrb applied per byte.
- Register bus timing and errors:
  - reg_ready_o tied to 1.
  - Reads are combinational: reg_rdata_o is valid in the same cycle as reg_valid_i.
  - Writes take effect at the next rising edge.
  - reg_error_o = reg_valid_i & (addr[3:0] not in {0x0, 0x4, 0x8}). Erroring writes change nothing; erroring reads return 0.
- CONTROL/STATUS writes:
  - Use only wstrb[0]; if wstrb[0] = 0 the write has no effect.
  - Writing CLR=1 sets clr_o high for exactly the one cycle following the write edge; clr_o is registered.
  - EN is updated by the same write, so writing 0x3 clears the counter and enables it.
- Counter update at each rising edge, first match wins:
  1. clr_o = 1: counter <= 0.
  2. ld_i = 1: counter <= ld_val_i.
  3. EN = 1 and counter == THRESHOLD[W-1:0]: counter <= 0 (wrap).
  4. EN = 1: counter <= counter + 1, modulo 2^W.
  5. Otherwise: hold.
- tc_o is combinational: tc_o = EN & ~clr_o & ~ld_i & (counter == THRESHOLD[W-1:0]). It is high exactly in the cycle whose edge performs the wrap.
- STATUS.TC is set at the edge where tc_o = 1. If a W1C write and tc_o occur in the same cycle, set wins.
- THRESHOLD bits above W are stored and read back, but ignored by the comparison.
- A threshold below the current count is not detected until the counter reaches 2^W-1, wraps to 0, and counts back up to the threshold.
- Asynchronous reset mid-operation returns every state to its reset value immediately.
- Simulation-only check: error if W is outside 1..32.

Test Plan:
1. Reset, then read 0x0 / 0x4 / 0x8 -> 0x0, 0x0, 0xFFFF_FFFF. cnt_o = 0, tc_o = 0, reg_error_o = 0.
2. Write THRESHOLD = 3, then CONTROL = 0x1 -> cnt_o sequence 1, 2, 3, 0, 1.
   - tc_o high only in the cycle cnt_o = 3.
   - STATUS reads 0x1 afterwards; writing 0x1 to STATUS then reads 0x0.
3. Counter enabled at value 5; pulse ld_i with ld_val_i = 0x100 -> cnt_o = 0x100 next cycle, then 0x101. With ld_i and CLR in the same cycle -> cnt_o = 0.
4. Write CONTROL = 0x3 while count = 7 -> clr_o high for one cycle, cnt_o = 0, then counting resumes at 1. CONTROL reads 0x1.
5. Write THRESHOLD = 0xAABBCCDD with wstrb = 4'b0101 over 0xFFFF_FFFF -> reads 0xFFBBFFDD. Access to 0xC -> reg_error_o = 1, rdata 0, no state change.
6. W = 4, THRESHOLD = 0xFFFF_FFFF, enabled -> counts 0..15, wraps to 0 with tc_o high at 15. Assert rst_ni mid-count -> cnt_o = 0 and EN = 0 immediately.
